// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: data width, instruction field
// positions, ALU opcode encoding and the sequencer FSM state encoding.
package alu_sequencer_pkg;

    localparam int DATA_W  = 10;
    localparam int INSTR_W = 10;

    localparam int OP_MSB        = 9;
    localparam int OP_LSB        = 8;
    localparam int RD_MSB        = 7;
    localparam int RD_LSB        = 6;
    localparam int RS_MSB        = 5;
    localparam int RS_LSB        = 4;
    localparam int RT_MSB        = 3;
    localparam int RT_LSB        = 2;
    localparam int USE_CARRY_BIT = 1;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_SHIFT = 2'b10,
        ALU_NOR   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/alu_sequencer_regfile4x10.sv
// Four-entry register file: two operand read ports, one debug read port,
// one synchronous write port, cleared by asynchronous reset.
module regfile4x10
    import alu_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [1:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [1:0]        raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg
);

    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata_a   = regs_q[raddr_a];
    assign rdata_b   = regs_q[raddr_b];
    assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer (IDLE->READ->EXEC->WB) driving an external
// combinational ALU, with a 4x10 register file and sticky carry/borrow flags.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               load_en,
    input  logic [1:0]         load_addr,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [1:0]         rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic [1:0]         alu_opcode,
    output logic [DATA_W-1:0]  alu_rs,
    output logic [DATA_W-1:0]  alu_rt,
    output logic               alu_cin,
    output logic               alu_bin,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_cout,
    input  logic               alu_bout,
    output logic               done,
    output logic               carry_flag,
    output logic               borrow_flag
);

    state_e            state_q, state_d;
    alu_op_e           op_q, op_d;
    logic [1:0]        rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic              use_carry_q, use_carry_d;
    alu_op_e           alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_rs_q, alu_rs_d, alu_rt_q, alu_rt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              cout_q, cout_d, bout_q, bout_d;
    logic              carry_flag_q, carry_flag_d, borrow_flag_q, borrow_flag_d;

    logic              rf_we;
    logic [1:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata, rf_rs_data, rf_rt_data;
    logic              unused_reserved;

    assign unused_reserved = instr[0];

    regfile4x10 u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (rs_q),
        .rdata_a   (rf_rs_data),
        .raddr_b   (rt_q),
        .rdata_b   (rf_rt_data),
        .raddr_dbg (rd_addr),
        .rdata_dbg (rd_data)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        use_carry_d   = use_carry_q;
        alu_opcode_d  = alu_opcode_q;
        alu_rs_d      = alu_rs_q;
        alu_rt_d      = alu_rt_q;
        result_d      = result_q;
        cout_d        = cout_q;
        bout_d        = bout_q;
        carry_flag_d  = carry_flag_q;
        borrow_flag_d = borrow_flag_q;
        rf_we         = 1'b0;
        rf_waddr      = rd_q;
        rf_wdata      = result_q;

        unique case (state_q)
            ST_IDLE: begin
                // A preload takes priority over accepting an instruction.
                if (load_en) begin
                    rf_we    = 1'b1;
                    rf_waddr = load_addr;
                    rf_wdata = load_data;
                end else if (instr_valid) begin
                    op_d        = alu_op_e'(instr[OP_MSB:OP_LSB]);
                    rd_d        = instr[RD_MSB:RD_LSB];
                    rs_d        = instr[RS_MSB:RS_LSB];
                    rt_d        = instr[RT_MSB:RT_LSB];
                    use_carry_d = instr[USE_CARRY_BIT];
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                alu_opcode_d = op_q;
                alu_rs_d     = rf_rs_data;
                alu_rt_d     = rf_rt_data;
                state_d      = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                cout_d   = alu_cout;
                bout_d   = alu_bout;
                state_d  = ST_WB;
            end
            ST_WB: begin
                rf_we = 1'b1;
                if (op_q == ALU_ADD) carry_flag_d  = cout_q;
                if (op_q == ALU_SUB) borrow_flag_d = bout_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= ALU_ADD;
            rd_q          <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            use_carry_q   <= 1'b0;
            alu_opcode_q  <= ALU_ADD;
            alu_rs_q      <= '0;
            alu_rt_q      <= '0;
            result_q      <= '0;
            cout_q        <= 1'b0;
            bout_q        <= 1'b0;
            carry_flag_q  <= 1'b0;
            borrow_flag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            use_carry_q   <= use_carry_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_rs_q      <= alu_rs_d;
            alu_rt_q      <= alu_rt_d;
            result_q      <= result_d;
            cout_q        <= cout_d;
            bout_q        <= bout_d;
            carry_flag_q  <= carry_flag_d;
            borrow_flag_q <= borrow_flag_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE) && !load_en;
    assign done        = (state_q == ST_WB);
    assign alu_opcode  = alu_opcode_q;
    assign alu_rs      = alu_rs_q;
    assign alu_rt      = alu_rt_q;
    assign alu_cin     = (op_q == ALU_ADD) && use_carry_q && carry_flag_q;
    assign alu_bin     = (op_q == ALU_SUB) && use_carry_q && borrow_flag_q;
    assign carry_flag  = carry_flag_q;
    assign borrow_flag = borrow_flag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU on the alu_* ports.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [9:0] instr;
    logic       instr_ready;
    logic       load_en;
    logic [1:0] load_addr;
    logic [9:0] load_data;
    logic [1:0] rd_addr;
    logic [9:0] rd_data;
    logic [1:0] alu_opcode;
    logic [9:0] alu_rs, alu_rt;
    logic       alu_cin, alu_bin;
    logic [9:0] alu_result;
    logic       alu_cout, alu_bout;
    logic       done, carry_flag, borrow_flag;

    int checks = 0;
    int errors = 0;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .alu_opcode  (alu_opcode),
        .alu_rs      (alu_rs),
        .alu_rt      (alu_rt),
        .alu_cin     (alu_cin),
        .alu_bin     (alu_bin),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .alu_bout    (alu_bout),
        .done        (done),
        .carry_flag  (carry_flag),
        .borrow_flag (borrow_flag)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add with carry, subtract with borrow, shift left, nor.
    always_comb begin
        logic [10:0] wide;
        wide       = 11'd0;
        alu_result = 10'd0;
        alu_cout   = 1'b0;
        alu_bout   = 1'b0;
        case (alu_opcode)
            2'b00: begin
                wide       = {1'b0, alu_rs} + {1'b0, alu_rt} + {10'd0, alu_cin};
                alu_result = wide[9:0];
                alu_cout   = wide[10];
            end
            2'b01: begin
                wide       = {1'b0, alu_rs} - {1'b0, alu_rt} - {10'd0, alu_bin};
                alu_result = wide[9:0];
                alu_bout   = wide[10];
            end
            2'b10:   alu_result = alu_rs << 1;
            default: alu_result = ~(alu_rs | alu_rt);
        endcase
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Preload one register; starts and ends at a falling edge.
    task automatic load_reg(input logic [1:0] a, input logic [9:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Issue one instruction from IDLE and measure cycles until done; ends in IDLE.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic uc,
                         output int lat, output logic cin_s);
        instr_valid = 1'b1;
        instr       = {op, rd, rs, rt, uc, 1'b0};
        lat   = -1;
        cin_s = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) instr_valid = 1'b0;
            if (c == 2) cin_s = alu_cin;
            if (done) begin
                lat = c;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = '0; load_en = 1'b0;
        load_addr = '0; load_data = '0; rd_addr = '0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (carry_flag !== 1'b0 || borrow_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got c=%b b=%b expected 0 0", carry_flag, borrow_flag); end
        checks++; if (alu_opcode !== 2'b00 || alu_rs !== 10'd0 || alu_rt !== 10'd0) begin errors++; $display("[TB] FAIL reset_alu_outs: got op=%b rs=%h rt=%h expected 0 0 0", alu_opcode, alu_rs, alu_rt); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            checks++; if (rd_data !== 10'd0) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected 000", i, rd_data); end
        end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", instr_ready); end
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic cin_s;
        load_reg(2'd1, 10'd3);
        load_reg(2'd2, 10'd5);
        issue(2'b00, 2'd0, 2'd1, 2'd2, 1'b0, lat, cin_s);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL add_latency: got %0d expected 3", lat); end
        rd_addr = 2'd0; #1;
        checks++; if (rd_data !== 10'd8) begin errors++; $display("[TB] FAIL add_result: got %0d expected 8", rd_data); end
        checks++; if (carry_flag !== 1'b0) begin errors++; $display("[TB] FAIL add_carry: got %b expected 0", carry_flag); end
        checks++; if (alu_rs !== 10'd3 || alu_rt !== 10'd5 || alu_opcode !== 2'b00) begin errors++; $display("[TB] FAIL add_operands: got op=%b rs=%0d rt=%0d expected 00 3 5", alu_opcode, alu_rs, alu_rt); end
        @(negedge clk);
    endtask

    task automatic test_sub();
        int lat; logic cin_s;
        load_reg(2'd1, 10'd10);
        load_reg(2'd2, 10'd3);
        issue(2'b01, 2'd3, 2'd1, 2'd2, 1'b0, lat, cin_s);
        rd_addr = 2'd3; #1;
        checks++; if (rd_data !== 10'd7) begin errors++; $display("[TB] FAIL sub_result: got %0d expected 7", rd_data); end
        checks++; if (borrow_flag !== 1'b0) begin errors++; $display("[TB] FAIL sub_borrow0: got %b expected 0", borrow_flag); end
        @(negedge clk);
        issue(2'b01, 2'd0, 2'd2, 2'd1, 1'b0, lat, cin_s);
        rd_addr = 2'd0; #1;
        checks++; if (rd_data !== 10'h3F9) begin errors++; $display("[TB] FAIL sub_wrap_result: got %h expected 3f9", rd_data); end
        checks++; if (borrow_flag !== 1'b1) begin errors++; $display("[TB] FAIL sub_borrow1: got %b expected 1", borrow_flag); end
        @(negedge clk);
    endtask

    task automatic test_carry_wrap();
        int lat; logic cin_s;
        load_reg(2'd1, 10'd1023);
        load_reg(2'd2, 10'd1);
        issue(2'b00, 2'd0, 2'd1, 2'd2, 1'b0, lat, cin_s);
        rd_addr = 2'd0; #1;
        checks++; if (rd_data !== 10'd0) begin errors++; $display("[TB] FAIL wrap_result: got %0d expected 0", rd_data); end
        checks++; if (carry_flag !== 1'b1) begin errors++; $display("[TB] FAIL wrap_carry: got %b expected 1", carry_flag); end
        @(negedge clk);
    endtask

    task automatic test_nor();
        int lat; logic cin_s;
        load_reg(2'd1, 10'h3FC);
        load_reg(2'd2, 10'h0EC);
        issue(2'b11, 2'd3, 2'd1, 2'd2, 1'b0, lat, cin_s);
        rd_addr = 2'd3; #1;
        checks++; if (rd_data !== 10'h003) begin errors++; $display("[TB] FAIL nor_result: got %h expected 003", rd_data); end
        checks++; if (carry_flag !== 1'b1 || borrow_flag !== 1'b1) begin errors++; $display("[TB] FAIL nor_flags: got c=%b b=%b expected 1 1", carry_flag, borrow_flag); end
        @(negedge clk);
    endtask

    task automatic test_use_carry();
        int lat; logic cin_s;
        load_reg(2'd1, 10'd0);
        load_reg(2'd2, 10'd0);
        issue(2'b00, 2'd0, 2'd1, 2'd2, 1'b1, lat, cin_s);
        checks++; if (cin_s !== 1'b1) begin errors++; $display("[TB] FAIL use_carry_cin: got %b expected 1", cin_s); end
        rd_addr = 2'd0; #1;
        checks++; if (rd_data !== 10'd1) begin errors++; $display("[TB] FAIL use_carry_result: got %0d expected 1", rd_data); end
        checks++; if (carry_flag !== 1'b0 || borrow_flag !== 1'b1) begin errors++; $display("[TB] FAIL use_carry_flags: got c=%b b=%b expected 0 1", carry_flag, borrow_flag); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        load_reg(2'd1, 10'd7);
        instr_valid = 1'b1;
        instr       = {2'b00, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0};
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
        checks++; if (carry_flag !== 1'b0 || borrow_flag !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got c=%b b=%b expected 0 0", carry_flag, borrow_flag); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", instr_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done: got %b expected 0 at cycle %0d", done, c); end
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            checks++; if (rd_data !== 10'd0) begin errors++; $display("[TB] FAIL midreset_reg%0d: got %h expected 000", i, rd_data); end
        end
        @(negedge clk);
    endtask

    task automatic test_load_priority();
        int lat;
        load_en = 1'b1; load_addr = 2'd2; load_data = 10'h155;
        instr_valid = 1'b1;
        instr = {2'b00, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0};
        #1;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL prio_ready_low: got %b expected 0", instr_ready); end
        @(negedge clk);
        load_en = 1'b0;
        rd_addr = 2'd2; #1;
        checks++; if (rd_data !== 10'h155) begin errors++; $display("[TB] FAIL prio_load: got %h expected 155", rd_data); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL prio_ready_next: got %b expected 1", instr_ready); end
        lat = -1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr_valid = 1'b0;
                load_en = 1'b1; load_addr = 2'd3; load_data = 10'h3FF;
            end else begin
                load_en = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        load_en = 1'b0;
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL prio_latency: got %0d expected 3", lat); end
        @(negedge clk);
        rd_addr = 2'd1; #1;
        checks++; if (rd_data !== 10'h2AA) begin errors++; $display("[TB] FAIL prio_result: got %h expected 2aa", rd_data); end
        rd_addr = 2'd3; #1;
        checks++; if (rd_data !== 10'h000) begin errors++; $display("[TB] FAIL busy_load_ignored: got %h expected 000", rd_data); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_carry_wrap();
        test_nor();
        test_use_carry();
        test_reset_mid_exec();
        test_load_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
